// File: rtl/pll_rst_seq.sv
// Reset sequencer for the 125 MHz PLL output domain.
//
// Synchronises the raw PLL lock, requires a run of stable lock samples before
// accepting it, holds resets for a fixed time afterwards, then releases the
// staged resets one by one. A sustained loss of lock re-asserts every reset,
// bumps a saturating event counter and sets a sticky flag.
//
// Ports:
//   clk        PLL output clock (125 MHz)
//   rst        synchronous active-high reset
//   pll_locked raw PLL lock, asynchronous to clk
//   clr_flag   single-cycle pulse clearing lock_lost
//   stage_rst  active-high reset per stage, bit 0 releases first
//   ready      high while all stages are released and lock holds
//   lock_lost  sticky lock-loss flag
//   loss_cnt   saturating lock-loss event count
module pll_rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILT   = 1024,
  parameter int unsigned LOSS_FILT   = 4,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              clr_flag,
  output logic [STAGES-1:0] stage_rst,
  output logic              ready,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  loss_cnt
);

  localparam int unsigned LockW   = $clog2(LOCK_FILT + 1);
  localparam int unsigned LossW   = $clog2(LOSS_FILT + 1);
  localparam int unsigned HoldW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned RelLast = (STAGES - 1) * STAGE_GAP;
  localparam int unsigned RelW    = (RelLast > 0) ? $clog2(RelLast + 1) : 1;

  typedef enum logic [1:0] {StWait, StHold, StRel, StRun} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [LockW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [LossW-1:0]         loss_f_q, loss_f_d;
  logic [HoldW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [RelW-1:0]          rel_cnt_q, rel_cnt_d;
  logic [STAGES-1:0]        stage_rst_q, stage_rst_d;
  logic                     ready_q, ready_d;
  logic                     lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]         loss_cnt_q, loss_cnt_d;
  logic                     lock_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    loss_f_d    = loss_f_q;
    hold_cnt_d  = hold_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    stage_rst_d = stage_rst_q;
    ready_d     = ready_q;
    lock_lost_d = clr_flag ? 1'b0 : lock_lost_q;
    loss_cnt_d  = loss_cnt_q;

    if (state_q != StWait && loss_f_q == LossW'(LOSS_FILT)) begin
      // Sustained loss: tear everything down; the set beats a coincident clear.
      state_d     = StWait;
      lock_cnt_d  = '0;
      loss_f_d    = '0;
      stage_rst_d = '1;
      ready_d     = 1'b0;
      lock_lost_d = 1'b1;
      if (loss_cnt_q != '1) begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end else begin
      if (state_q != StWait) begin
        loss_f_d = lock_s ? '0 : loss_f_q + 1'b1;
      end
      unique case (state_q)
        StWait: begin
          stage_rst_d = '1;
          ready_d     = 1'b0;
          if (lock_cnt_q == LockW'(LOCK_FILT)) begin
            state_d    = StHold;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
            loss_f_d   = '0;
          end else begin
            lock_cnt_d = lock_s ? lock_cnt_q + 1'b1 : '0;
          end
        end
        StHold: begin
          if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
            // Stage 0 drops on the very edge REL is entered.
            state_d        = StRel;
            rel_cnt_d      = '0;
            stage_rst_d[0] = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StRel: begin
          if (rel_cnt_q == RelW'(RelLast)) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
            for (int unsigned k = 0; k < STAGES; k++) begin
              if (32'(rel_cnt_d) >= k * STAGE_GAP) begin
                stage_rst_d[k] = 1'b0;
              end
            end
          end
        end
        StRun: begin
          stage_rst_d = '0;
          ready_d     = 1'b1;
        end
        default: state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWait;
      sync_q      <= '0;
      lock_cnt_q  <= '0;
      loss_f_q    <= '0;
      hold_cnt_q  <= '0;
      rel_cnt_q   <= '0;
      stage_rst_q <= '1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      lock_cnt_q  <= lock_cnt_d;
      loss_f_q    <= loss_f_d;
      hold_cnt_q  <= hold_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      stage_rst_q <= stage_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign stage_rst = stage_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus a randomized run, all checked
// against a timestamp-based reference model of the sequencing rules.
module tb_pll_rst_seq;

  localparam int SYNC  = 2;
  localparam int LF    = 8;
  localparam int LOSSF = 4;
  localparam int HOLD  = 4;
  localparam int S     = 3;
  localparam int GAP   = 2;
  localparam int CW    = 2;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int EW    = S + 2 + CW;

  logic          clk = 1'b0;
  logic          rst, pll_locked, clr_flag;
  logic [S-1:0]  stage_rst;
  logic          ready, lock_lost;
  logic [CW-1:0] loss_cnt;

  always #4 clk = ~clk;

  pll_rst_seq #(
    .SYNC_STAGES(SYNC), .LOCK_FILT(LF), .LOSS_FILT(LOSSF), .HOLD_CYCLES(HOLD),
    .STAGES(S), .STAGE_GAP(GAP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .clr_flag(clr_flag),
    .stage_rst(stage_rst), .ready(ready), .lock_lost(lock_lost), .loss_cnt(loss_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: lock_s is pll_locked through a SYNC-deep delay line. Once
  // lock is accepted at edge m_acc, all outputs follow from elapsed time.
  logic [SYNC-1:0] m_dly = '0;
  bit m_wait = 1'b1;
  bit m_lost = 1'b0;
  int m_hi = 0, m_lo = 0, m_acc = 0, m_edge = 0, m_cnt = 0;

  task automatic tick(input logic pl, input logic clr, input logic r);
    logic ls;
    bit ev;
    pll_locked = pl;
    clr_flag   = clr;
    rst        = r;
    @(posedge clk);
    m_edge++;
    ls = m_dly[SYNC-1];
    if (r) begin
      m_dly = '0; m_wait = 1'b1; m_hi = 0; m_lo = 0; m_cnt = 0; m_lost = 1'b0;
    end else begin
      ev = 1'b0;
      m_dly = {m_dly[SYNC-2:0], pl};
      if (m_wait) begin
        if (m_hi == LF) begin
          m_wait = 1'b0; m_acc = m_edge; m_hi = 0; m_lo = 0;
        end else begin
          m_hi = ls ? m_hi + 1 : 0;
        end
      end else if (m_lo == LOSSF) begin
        ev = 1'b1; m_wait = 1'b1; m_hi = 0; m_lo = 0; m_lost = 1'b1;
        if (m_cnt < MAXC) m_cnt++;
      end else begin
        m_lo = ls ? 0 : m_lo + 1;
      end
      if (!ev && clr) m_lost = 1'b0;
    end
    #1;
  endtask

  function automatic logic [EW-1:0] m_exp();
    logic [S-1:0] stg;
    logic rdy;
    int rel;
    rel = m_edge - m_acc - HOLD;
    for (int k = 0; k < S; k++) stg[k] = m_wait ? 1'b1 : (rel < k * GAP);
    rdy = !m_wait && (rel >= (S - 1) * GAP + 1);
    return {stg, rdy, m_lost, CW'(m_cnt)};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {stage_rst, ready, lock_lost, loss_cnt};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if (obs() !== {3'b111, 1'b0, 1'b0, 2'b00}) begin
        failures++;
        $display("FAIL reset_state got=%b exp=%b", obs(), {3'b111, 4'b0000});
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL reset_idle i=%0d got=%b exp=%b", i, obs(), m_exp());
      end
    end
  endtask

  task automatic test_startup();
    logic [S-1:0] es;
    for (int e = 0; e < 25; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL startup_model e=%0d got=%b exp=%b", e, obs(), m_exp());
      end
      es = (e < 14) ? 3'b111 : (e < 16) ? 3'b110 : (e < 18) ? 3'b100 : 3'b000;
      checks++;
      if ({stage_rst, ready, lock_lost, loss_cnt} !== {es, e >= 19, 1'b0, 2'b00}) begin
        failures++;
        $display("FAIL startup_timing e=%0d got=%b exp=%b", e, obs(), {es, e >= 19, 3'b000});
      end
    end
  endtask

  task automatic test_run_glitch();
    for (int i = 0; i < 13; i++) begin
      tick(i >= 3, 1'b0, 1'b0);
      checks++;
      if (obs() !== m_exp() || ready !== 1'b1 || loss_cnt !== 2'd0) begin
        failures++;
        $display("FAIL run_glitch i=%0d got=%b exp=%b", i, obs(), m_exp());
      end
    end
  endtask

  task automatic test_loss();
    for (int i = 0; i < 27; i++) begin
      tick(i >= 6, 1'b0, 1'b0);
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL loss_model i=%0d got=%b exp=%b", i, obs(), m_exp());
      end
      if (i == 5 || i == 6 || i == 24 || i == 25) begin
        checks++;
        if ((i == 5 && ready !== 1'b1) ||
            (i == 6 && obs() !== {3'b111, 1'b0, 1'b1, 2'b01}) ||
            (i == 24 && ready !== 1'b0) || (i == 25 && ready !== 1'b1)) begin
          failures++;
          $display("FAIL loss_timing i=%0d got=%b", i, obs());
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 39; e++) begin
      tick(1'b1, 1'b0, (e == 16 || e == 17));
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL rst_mid_model e=%0d got=%b exp=%b", e, obs(), m_exp());
      end
      if (e == 15 || e == 16 || e == 17 || e == 36 || e == 37) begin
        checks++;
        if ((e == 15 && stage_rst !== 3'b110) ||
            ((e == 16 || e == 17) && obs() !== {3'b111, 4'b0000}) ||
            (e == 36 && ready !== 1'b0) || (e == 37 && ready !== 1'b1)) begin
          failures++;
          $display("FAIL rst_mid_timing e=%0d got=%b", e, obs());
        end
      end
    end
  endtask

  task automatic test_wait_glitch();
    tick(1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 24; e++) begin
      tick(e != 7, 1'b0, 1'b0);
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL wait_glitch_model e=%0d got=%b exp=%b", e, obs(), m_exp());
      end
      if (e == 21 || e == 22) begin
        checks++;
        if (stage_rst[0] !== (e == 21)) begin
          failures++;
          $display("FAIL wait_glitch_timing e=%0d got=%b exp=%b", e, stage_rst[0], e == 21);
        end
      end
    end
  endtask

  task automatic test_saturate();
    bit pend, hit;
    tick(1'b0, 1'b0, 1'b1);
    for (int ev = 0; ev < 4; ev++) begin
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        pend = !m_wait && (m_lo == LOSSF);
        tick(1'b0, pend && ev == 1, 1'b0);
        checks++;
        if (obs() !== m_exp()) begin
          failures++;
          $display("FAIL sat_model ev=%0d i=%0d got=%b exp=%b", ev, i, obs(), m_exp());
        end
        hit = pend;
      end
      checks++;
      if (!hit || lock_lost !== 1'b1 || loss_cnt !== CW'((ev < 3) ? ev + 1 : 3)) begin
        failures++;
        $display("FAIL sat_event ev=%0d hit=%0b lost=%b cnt=%0d", ev, hit, lock_lost, loss_cnt);
      end
    end
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if (lock_lost !== 1'b0 || loss_cnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_clear got lost=%b cnt=%0d exp lost=0 cnt=3", lock_lost, loss_cnt);
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b1;
    int left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        left = lvl ? $urandom_range(1, 40) : $urandom_range(1, 8);
      end
      left--;
      tick(lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL random i=%0d got=%b exp=%b", i, obs(), m_exp());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    clr_flag = 1'b0;
    test_reset();
    test_startup();
    test_run_glitch();
    test_loss();
    test_rst_mid();
    test_wait_glitch();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset sequencer directly downstream of the 48→125 MHz PLL.
- Clocked by the PLL's 125 MHz output.
- Synchronises and glitch-filters the PLL lock signal, holds the system in reset until lock is stable, then releases reset to the design's sub-domains in a fixed staggered order.
- On lock loss it re-asserts all resets and records the event for software/debug.

Parameters:
- SYNC_STAGES, 2, flops in the lock synchroniser (≥2).
- LOCK_FILT, 1024, consecutive synchronised-high cycles required to accept lock (≥1).
- LOSS_FILT, 4, consecutive synchronised-low cycles required to declare lock loss (≥1).
- HOLD_CYCLES, 256, extra cycles resets stay asserted after lock is accepted (≥1).
- STAGES, 3, number of staged reset outputs (≥1).
- STAGE_GAP, 16, cycles between successive stage releases (≥1).
- CNT_W, 8, width of the lock-loss event counter.

Ports:
- clk  in  1  PLL output clock, 125 MHz.
- rst  in  1  synchronous active-high reset.
- pll_locked  in  1  raw PLL lock; asynchronous to clk.
- clr_flag  in  1  1-cycle pulse; clears lock_lost.
- stage_rst  out  STAGES  active-high reset per stage; bit 0 releases first.
- ready  out  1  high while all stages are released and lock holds.
- lock_lost  out  1  sticky; set on each lock-loss event.
- loss_cnt  out  CNT_W  saturating count of lock-loss events.

Behaviour:
- All outputs registered.
- Reset (rst=1 at an edge):
  - Next cycle: stage_rst all 1, ready 0, lock_lost 0, loss_cnt 0.
  - Synchroniser flops 0, filter counters 0, state WAIT.
  - Applies from any state, including mid-release.
  - No effect while clk is stopped; this is accepted by design.
- lock_s is the last synchroniser flop output, i.e. pll_locked delayed SYNC_STAGES edges.
- Cycle numbering in this spec: edge 0 = first edge sampling pll_locked=1.
- WAIT:
  - stage_rst all 1, ready 0.
  - Filter counter increments on lock_s=1 and clears on lock_s=0.
  - After LOCK_FILT consecutive highs → HOLD.
- HOLD:
  - Resets stay asserted for HOLD_CYCLES cycles, then → REL.
- REL:
  - stage_rst[k] falls at REL entry + k*STAGE_GAP.
  - After the last stage falls, ready rises on the following cycle and the state → RUN.
  - Once released, a stage is not re-asserted except by a lock-loss event or rst.
- RUN:
  - stage_rst all 0, ready 1.
- Loss filter:
  - Active in HOLD, REL and RUN.
  - Counts consecutive lock_s=0 cycles and clears on any lock_s=1.
  - On reaching LOSS_FILT: next cycle stage_rst all 1 and ready 0.
  - Same cycle as that assertion: loss_cnt increments (saturates at 2^CNT_W−1) and lock_lost is set.
  - State → WAIT with the lock filter cleared.
  - A loss during HOLD or REL counts as an event as well.
- Glitches:
  - A low glitch on lock_s shorter than LOSS_FILT cycles is ignored in all states.
  - In WAIT, any single low sample restarts the lock filter.
- lock_lost:
  - clr_flag clears it.
  - If clr_flag and a loss event occur in the same cycle, set wins.
- With STAGES=1, ready rises the cycle after stage_rst[0] falls.
- Counters are sized to their parameters (clog2); no wrap-around in any filter counter.

Test Plan (SYNC_STAGES=2, LOCK_FILT=8, LOSS_FILT=4, HOLD_CYCLES=4, STAGES=3, STAGE_GAP=2, CNT_W=2 unless stated):
1. rst pulse, then pll_locked=1 held from edge 0 → lock_s=1 at edge 2, HOLD at edge 10, REL at 14. stage_rst[0] falls at 14, [1] at 16, [2] at 18; ready=1 at 19; lock_lost=0, loss_cnt=0.
2. In RUN, pll_locked low for 3 cycles then high → no change: ready stays 1, loss_cnt stays 0.
3. In RUN, pll_locked low for 6 cycles → one cycle after the 4th lock_s=0 sample: stage_rst=3'b111, ready=0, lock_lost=1, loss_cnt=1. pll_locked then high continuously → full scenario-1 timing repeats relative to the new first high sample.
4. In WAIT, pll_locked high 7 cycles, low 1 cycle, then high → HOLD entered only 8 cycles after the re-rise, not before.
5. rst asserted at edge 16 (stage 0 released, stage 1 not yet) → edge 17: stage_rst=3'b111, ready=0, lock_lost=0, loss_cnt=0; sequence restarts after rst drops.
6. Four lock-loss events with clr_flag pulsed coincident with the 2nd event → loss_cnt saturates at 3. lock_lost=1 after every event (set wins over clr); a clr_flag pulse with no event clears it to 0.
